lcd_reset_seq: RTL and testbench
================================

# lcd_reset_seq

Parametrised reset sequencer for the ILI9341 panel interface. It drives the panel's hardware reset line low (or a caller-chosen level) for a configurable number of cycles, then holds it high for a configurable recovery time before reporting completion. It sits between the top-level init controller and the LCD reset pin, and succeeds the fixed-width single-wait reset block. Generalisations over that block: independent pulse and recovery lengths, a busy flag, a captured level, and an optional automatic power-up sequence.

## Interface
- PULSE_CYCLES, 16: cycles the reset line is driven with the captured level; must be ≥ 1.
- WAIT_CYCLES, 32: recovery cycles with the line high before completion; must be ≥ 1.
- CNT_W, derived localparam: $clog2(max(PULSE_CYCLES, WAIT_CYCLES)); minimum 1.

- clk  input  1  system clock, single clock domain.
- rst  input  1  asynchronous, active-low reset.
- i_start  input  1  start request, sampled only in IDLE.
- i_reset_val  input  1  level driven during pulse phase (0 = real reset, 1 = dummy timed wait); captured with i_start.
- o_lcd_rst  output  1  registered reset line to panel, active-low.
- o_busy  output  1  high while a sequence is in progress (ASSERT, WAIT, DONE).
- o_done  output  1  one-cycle completion pulse.

## Operation
- Registers: state, down-counter cnt[CNT_W-1:0], captured level r_val.
- States: IDLE, ASSERT, WAIT, DONE.
- IDLE → ASSERT when i_start=1.
  - On this transition, load cnt ← PULSE_CYCLES-1 and capture r_val ← i_reset_val.
- ASSERT:
  - o_lcd_rst = r_val.
  - If cnt==0: go to WAIT and load cnt ← WAIT_CYCLES-1; else cnt decrements.
- WAIT:
  - o_lcd_rst = 1.
  - If cnt==0: go to DONE; else cnt decrements.
- DONE:
  - o_lcd_rst = 1, o_done = 1, then → IDLE unconditionally.
- IDLE outputs: o_lcd_rst = 1, o_busy = 0, o_done = 0.
- Illegal state encodings → IDLE.
- All outputs come from flops; no combinational path from input to output.
- i_start outside IDLE is ignored; it is not queued.
- i_reset_val changes after capture have no effect.
- Counter arithmetic is unsigned and never wraps: the load happens at the phase boundary, so there is no underflow.

## Timing
- Reset values: state=IDLE, cnt=0, r_val=1, o_lcd_rst=1, o_busy=0, o_done=0.
- i_start sampled high at edge T:
  - o_lcd_rst = r_val from edge T+1 for exactly PULSE_CYCLES cycles.
  - o_lcd_rst = 1 for WAIT_CYCLES cycles.
  - o_done = 1 for one cycle starting at edge T+1+PULSE_CYCLES+WAIT_CYCLES.
- o_busy is high from edge T+1 through the DONE cycle inclusive.
  - Busy duration: PULSE_CYCLES+WAIT_CYCLES+1 cycles.
- Back-to-back operation:
  - i_start held high during DONE is ignored.
  - i_start high in the first IDLE cycle after DONE starts a new sequence.
  - Minimum start-to-start spacing: PULSE_CYCLES+WAIT_CYCLES+2 cycles.
- rst asserted mid-sequence:
  - All outputs return to their reset values asynchronously; o_lcd_rst goes high immediately.
  - No o_done is emitted.
  - After release, the block behaves per Configuration.

## Configuration
- LCD_RESET_SEQ_POWERUP_EN defined:
  - On the first clk edge after rst deasserts, the block leaves IDLE as if i_start=1 and i_reset_val=0.
  - One flop (r_pwrup, reset to 1, cleared on that first edge) guarantees exactly one automatic sequence per rst release.
  - i_start in that first cycle is absorbed into the same sequence.
- Not defined:
  - No automatic sequence; the block stays in IDLE until i_start.

## Test plan
- Reset with PULSE=4, WAIT=6, macro off:
  - During and after rst low: o_lcd_rst=1, o_busy=0, o_done=0.
  - Outputs stay in IDLE values for 20 cycles with i_start=0.
- i_start=1, i_reset_val=0 for one cycle at edge T:
  - o_lcd_rst=0 at edges T+1..T+4, high at T+5..T+10.
  - o_done=1 only at T+11; o_busy high T+1..T+11.
- i_reset_val=1 with i_start:
  - o_lcd_rst stays 1 throughout.
  - o_done still at T+11 (dummy wait).
  - Toggling i_reset_val mid-ASSERT in the i_reset_val=0 case does not change o_lcd_rst.
- i_start held high continuously:
  - Sequences repeat with o_done pulses 12 cycles apart.
  - No start is accepted while o_busy=1.
- rst pulled low at T+3 of a sequence:
  - o_lcd_rst goes to 1 asynchronously; no o_done.
  - After release, idle until the next i_start.
- Macro on:
  - Release rst → o_lcd_rst=0 for 4 cycles starting one edge after release, then o_done.
  - Exactly one automatic sequence occurs; a second sequence requires i_start.

Source files
------------

// File: rtl/lcd_reset_seq.sv
// Timed reset-pulse sequencer for the ILI9341 panel reset pin: pulse phase, recovery phase, done pulse.
// Optional: define LCD_RESET_SEQ_POWERUP_EN to run one automatic sequence after every rst release.
module lcd_reset_seq #(
    parameter int PULSE_CYCLES = 16,
    parameter int WAIT_CYCLES  = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_reset_val,
    output logic o_lcd_rst,
    output logic o_busy,
    output logic o_done
);
    localparam int MAX_CYCLES = (PULSE_CYCLES > WAIT_CYCLES) ? PULSE_CYCLES : WAIT_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             r_val_q;
    logic             lcd_rst_q;
    logic             busy_q;
    logic             done_q;
    logic             start_d;
    logic             val_d;

`ifdef LCD_RESET_SEQ_POWERUP_EN
    logic pwrup_q;

    // The first edge after release behaves like a real-reset start request.
    assign start_d = i_start | pwrup_q;
    assign val_d   = pwrup_q ? 1'b0 : i_reset_val;
`else
    assign start_d = i_start;
    assign val_d   = i_reset_val;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            r_val_q   <= 1'b1;
            lcd_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LCD_RESET_SEQ_POWERUP_EN
            pwrup_q   <= 1'b1;
`endif
        end else begin
`ifdef LCD_RESET_SEQ_POWERUP_EN
            pwrup_q   <= 1'b0;
`endif
            // Outputs register the current state, so they trail the state by one edge.
            lcd_rst_q <= (state_q == ST_ASSERT) ? r_val_q : 1'b1;
            busy_q    <= (state_q != ST_IDLE);
            done_q    <= (state_q == ST_DONE);

            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        state_q <= ST_ASSERT;
                        cnt_q   <= PULSE_LOAD;
                        r_val_q <= val_d;
                    end
                end
                ST_ASSERT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= WAIT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_lcd_rst = lcd_rst_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
endmodule

// File: tb/tb_lcd_reset_seq.sv
// Directed bench for lcd_reset_seq with PULSE_CYCLES=4, WAIT_CYCLES=6; outputs sampled 1 time unit after each rising edge.
module tb_lcd_reset_seq;
    localparam int P = 4;
    localparam int W = 6;

    logic clk;
    logic rst;
    logic i_start;
    logic i_reset_val;
    logic o_lcd_rst;
    logic o_busy;
    logic o_done;

    int tests_run;
    int tests_failed;

    lcd_reset_seq #(
        .PULSE_CYCLES(P),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_reset_val(i_reset_val),
        .o_lcd_rst  (o_lcd_rst),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, " lcd_rst"}, {31'd0, o_lcd_rst}, 32'd1);
        check({tag, " busy"},    {31'd0, o_busy},    32'd0);
        check({tag, " done"},    {31'd0, o_done},    32'd0);
    endtask

    // Called just after edge T (where start was sampled); checks edges T+1..T+12.
    // When toggle_val is set, i_reset_val is flipped mid-pulse to prove it was captured.
    task automatic check_seq(input string name, input logic lvl, input logic toggle_val);
        for (int k = 1; k <= P + W + 2; k++) begin
            tick();
            check($sformatf("%s k=%0d lcd_rst", name, k), {31'd0, o_lcd_rst},
                  {31'd0, ((k <= P) ? lvl : 1'b1)});
            check($sformatf("%s k=%0d busy", name, k), {31'd0, o_busy},
                  {31'd0, (k <= P + W + 1)});
            check($sformatf("%s k=%0d done", name, k), {31'd0, o_done},
                  {31'd0, (k == P + W + 1)});
            if (toggle_val && k == 2) i_reset_val = ~i_reset_val;
        end
        $display("[TB] sequence %s level=%0d checked", name, lvl);
    endtask

    task automatic start_one(input logic val);
        i_start     = 1'b1;
        i_reset_val = val;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        i_start      = 1'b0;
        i_reset_val  = 1'b0;

        repeat (3) tick();
        check_idle("in_reset");
        @(negedge clk);
        rst = 1'b1;

`ifdef LCD_RESET_SEQ_POWERUP_EN
        @(posedge clk);
        #1;
        check_seq("powerup", 1'b0, 1'b0);
`endif
        for (int k = 0; k < 20; k++) begin
            tick();
            check_idle($sformatf("idle%0d", k));
        end
        $display("[TB] idle after reset release checked");

        start_one(1'b0);
        check_seq("real_reset", 1'b0, 1'b1);

        start_one(1'b1);
        check_seq("dummy_wait", 1'b1, 1'b0);

        // Held start: second sequence accepted one cycle after DONE, so done pulses are P+W+2 apart.
        i_start     = 1'b1;
        i_reset_val = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 2 * (P + W + 2); k++) begin
            tick();
            check($sformatf("held k=%0d lcd_rst", k), {31'd0, o_lcd_rst},
                  {31'd0, !((k >= 1 && k <= P) || (k >= P + W + 3 && k <= 2 * P + W + 2))});
            check($sformatf("held k=%0d busy", k), {31'd0, o_busy},
                  {31'd0, ((k >= 1 && k <= P + W + 1) || (k >= P + W + 3 && k <= 2 * (P + W) + 3))});
            check($sformatf("held k=%0d done", k), {31'd0, o_done},
                  {31'd0, (k == P + W + 1 || k == 2 * (P + W) + 3)});
            if (k == 2 * (P + W) + 3) i_start = 1'b0;
        end
        $display("[TB] held-start back-to-back sequences checked");

        // Reset mid-sequence: outputs return asynchronously, no done afterwards.
        start_one(1'b0);
        for (int k = 1; k <= 3; k++) tick();
        check("pre_abort lcd_rst", {31'd0, o_lcd_rst}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check_idle("abort_async");
        repeat (2) tick();
        check_idle("abort_hold");
        @(negedge clk);
        rst = 1'b1;
`ifdef LCD_RESET_SEQ_POWERUP_EN
        @(posedge clk);
        #1;
        check_seq("powerup2", 1'b0, 1'b0);
`endif
        for (int k = 0; k < 15; k++) begin
            tick();
            check_idle($sformatf("post_abort%0d", k));
        end
        $display("[TB] mid-sequence reset checked");

        start_one(1'b0);
        check_seq("after_abort", 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
